// File: rtl/abs_diff_arbiter.sv
// Round-robin arbiter over four requesters that share one |x - y| datapath.
// Stage 1 picks a winner, acknowledges it and captures its operands. Stage 2
// computes the absolute difference one edge later and presents it with the
// winner's index.
module abs_diff_arbiter #(
    parameter int WIDTH = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] x_in,
    input  logic [4*WIDTH-1:0] y_in,
    input  logic               hold,
    output logic [3:0]         ack,
    output logic [WIDTH-1:0]   result,
    output logic [1:0]         result_id,
    output logic               result_valid,
    output logic               idle
);

    // The requester count is structural (2-bit ids, 4-bit masks), so it is not a parameter.
    localparam int NREQ = 4;

    // Unsigned absolute difference. Subtracting the smaller operand from the
    // larger one means the result never wraps.
    function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        if (a > b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // Round-robin pick.
    // Returns {found, index} for the first set bit of elig, searching ptr,
    // ptr+1, ... modulo 4. The loop walks from the farthest offset to the
    // nearest, so the nearest eligible index overwrites any farther one.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] elig,
                                           input logic [1:0]      ptr);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int n = NREQ - 1; n >= 0; n--) begin
            idx = ptr + 2'(n);
            if (elig[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    logic [1:0]       ptr_q,          ptr_d;
    logic [3:0]       ack_q,          ack_d;
    logic [WIDTH-1:0] x_q,            x_d;
    logic [WIDTH-1:0] y_q,            y_d;
    logic [1:0]       id_q,           id_d;
    logic [WIDTH-1:0] result_q,       result_d;
    logic [1:0]       result_id_q,    result_id_d;
    logic             result_valid_q, result_valid_d;

    logic [3:0]       elig_s;
    logic [2:0]       pick_s;
    logic             grant_s;
    logic [1:0]       win_s;

    // Next-state logic for the arbitration stage and the abs-diff stage.
    always_comb begin
        ptr_d          = ptr_q;
        ack_d          = 4'b0000;
        x_d            = x_q;
        y_d            = y_q;
        id_d           = id_q;
        result_d       = result_q;
        result_id_d    = result_id_q;
        result_valid_d = 1'b0;

        // A requester acked this cycle still has req high. Masking it out here
        // prevents a second grant for the same request.
        elig_s  = req & ~ack_q;
        pick_s  = rr_pick(elig_s, ptr_q);
        grant_s = pick_s[2] & ~hold;
        win_s   = pick_s[1:0];

        if (grant_s) begin
            ack_d       = 4'b0001 << win_s;
            x_d         = x_in[int'(win_s) * WIDTH +: WIDTH];
            y_d         = y_in[int'(win_s) * WIDTH +: WIDTH];
            id_d        = win_s;
            ptr_d       = win_s + 2'd1;
        end else begin
            ack_d       = 4'b0000;
        end

        // A grant made on the previous edge is turned into a result on this edge.
        if (|ack_q) begin
            result_d       = abs_diff(x_q, y_q);
            result_id_d    = id_q;
            result_valid_d = 1'b1;
        end else begin
            result_valid_d = 1'b0;
        end
    end

    // State registers. A synchronous reset clears both stages, which drops any in-flight work.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q          <= 2'd0;
            ack_q          <= 4'b0000;
            x_q            <= '0;
            y_q            <= '0;
            id_q           <= 2'd0;
            result_q       <= '0;
            result_id_q    <= 2'd0;
            result_valid_q <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            ack_q          <= ack_d;
            x_q            <= x_d;
            y_q            <= y_d;
            id_q           <= id_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign ack          = ack_q;
    assign result       = result_q;
    assign result_id    = result_id_q;
    assign result_valid = result_valid_q;
    assign idle         = ~(|ack_q) & ~result_valid_q;

endmodule

// File: tb/tb_abs_diff_arbiter.sv
// Self-checking bench for abs_diff_arbiter.
// It runs directed scenarios first, then randomized traffic. A cycle-level
// scoreboard model predicts every output after every rising edge.
module tb_abs_diff_arbiter;

    localparam int WIDTH = 10;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic               clock;
    logic               reset;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] x_in;
    logic [4*WIDTH-1:0] y_in;
    logic               hold;
    logic [3:0]         ack;
    logic [WIDTH-1:0]   result;
    logic [1:0]         result_id;
    logic               result_valid;
    logic               idle;

    abs_diff_arbiter #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .x_in         (x_in),
        .y_in         (y_in),
        .hold         (hold),
        .ack          (ack),
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid),
        .idle         (idle)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests = 0;
    int fails = 0;

    // Reference model state: what the outputs must show after the latest edge.
    typedef struct { int res; int id; } pend_t;
    pend_t    pend[$];
    logic [3:0] m_ack  = 4'b0000;
    int         m_ptr  = 0;
    int         m_res  = 0;
    int         m_rid  = 0;
    bit         m_rv   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Advance the model by one edge, using the inputs as they stand at the edge.
    task automatic model_edge();
        logic [3:0] new_ack;
        bit found;
        int i, xv, yv;
        pend_t p;
        if (reset) begin
            pend.delete();
            m_ack = 4'b0000;
            m_ptr = 0;
            m_res = 0;
            m_rid = 0;
            m_rv  = 1'b0;
        end else begin
            m_rv = 1'b0;
            if (pend.size() > 0) begin
                p = pend.pop_front();
                m_res = p.res;
                m_rid = p.id;
                m_rv  = 1'b1;
            end
            new_ack = 4'b0000;
            found   = 1'b0;
            if (!hold) begin
                for (int n = 0; n < 4; n++) begin
                    i = (m_ptr + n) % 4;
                    if (!found && req[i] && !m_ack[i]) begin
                        found = 1'b1;
                        new_ack[i] = 1'b1;
                        xv = int'(x_in[i*WIDTH +: WIDTH]);
                        yv = int'(y_in[i*WIDTH +: WIDTH]);
                        p.res = (xv > yv) ? xv - yv : yv - xv;
                        p.id  = i;
                        pend.push_back(p);
                        m_ptr = (i + 1) % 4;
                    end
                end
            end
            m_ack = new_ack;
        end
    endtask

    // One clock: update the model at the edge, then compare every output 1 ns later.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("ack",          32'(ack),          32'(m_ack));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("result",       32'(result),       32'(m_res));
        check("result_id",    32'(result_id),    32'(m_rid));
        check("idle",         32'(idle),         32'((m_ack == 4'b0000) && !m_rv));
    endtask

    task automatic set_ops(input int idx, input int xv, input int yv);
        x_in[idx*WIDTH +: WIDTH] = WIDTH'(xv);
        y_in[idx*WIDTH +: WIDTH] = WIDTH'(yv);
    endtask

    // Single request on requester 0 with a fixed expected |x - y|.
    task automatic single(input int xv, input int yv, input int expv, input string tag);
        set_ops(0, xv, yv);
        req = 4'b0001;
        tick();
        check({tag, "_ack"}, 32'(ack), 32'd1);
        req = 4'b0000;
        tick();
        check({tag, "_res"}, 32'(result), 32'(expv));
        check({tag, "_rv"},  32'(result_valid), 32'd1);
        tick();
    endtask

    logic [3:0] exp_seq [4];
    logic [3:0] rnd;

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        hold  = 1'b0;
        x_in  = '0;
        y_in  = '0;
        #1;

        // Reset state.
        tick();
        tick();
        check("reset_idle",  32'(idle), 32'd1);
        check("reset_res",   32'(result), 32'd0);
        reset = 1'b0;

        // Single request on requester 2. Its operands change after the grant edge.
        set_ops(2, 300, 100);
        req = 4'b0100;
        tick();
        check("single_ack", 32'(ack), 32'd4);
        req = 4'b0000;
        set_ops(2, 7, 900);
        tick();
        check("single_res", 32'(result), 32'd200);
        check("single_id",  32'(result_id), 32'd2);
        check("single_rv",  32'(result_valid), 32'd1);
        tick();
        check("single_keep", 32'(result), 32'd200);

        // Arithmetic corners.
        single(5, 900, 895, "c_5_900");
        single(512, 512, 0, "c_eq");
        single(1023, 0, 1023, "c_max_x");
        single(0, 1023, 1023, "c_max_y");

        // All four requesters are held from reset release; each drops its req after its ack.
        for (int i = 0; i < 4; i++) set_ops(i, 10 * i, 100);
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        reset = 1'b0;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_ack", 32'(ack), 32'(exp_seq[i]));
            if (i > 0) check("rr_id", 32'(result_id), 32'(i - 1));
            req = req & ~m_ack;
        end
        tick();
        check("rr_id_last", 32'(result_id), 32'd3);
        check("rr_rv_last", 32'(result_valid), 32'd1);
        tick();

        // One requester holds req permanently, so it is acked only every other cycle.
        req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("held_ack", 32'(ack), (i % 2 == 0) ? 32'd2 : 32'd0);
        end
        req = 4'b0000;
        tick();
        tick();

        // hold blocks new grants, and the pointer resumes after index 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        tick();
        check("hold_first", 32'(ack), 32'd1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_noack", 32'(ack), 32'd0);
        end
        hold = 1'b0;
        tick();
        check("hold_release", 32'(ack), 32'd2);
        req = 4'b0000;
        tick();
        tick();

        // A reset pulse kills a pending result and resets the pointer.
        set_ops(0, 50, 20);
        req = 4'b0001;
        tick();
        check("rst_mid_ack", 32'(ack), 32'd1);
        req   = 4'b0000;
        reset = 1'b1;
        tick();
        check("rst_mid_rv",  32'(result_valid), 32'd0);
        check("rst_mid_res", 32'(result), 32'd0);
        reset = 1'b0;
        req   = 4'b1001;
        tick();
        check("rst_mid_next", 32'(ack), 32'd1);
        req = 4'b0000;
        tick();
        check("rst_mid_rv2", 32'(result_valid), 32'd1);
        tick();

        // Randomized traffic with occasional hold and reset pulses.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            rnd   = 4'($urandom) & 4'($urandom);
            req   = (req & ~m_ack) | rnd;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       set_ops(i, 0, int'($urandom_range(0, MAXV)));
                    1:       set_ops(i, MAXV, int'($urandom_range(0, MAXV)));
                    default: set_ops(i, int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)));
                endcase
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
